// File: rtl/sweep_pkg.sv
// Shared types and width helpers for the
// partition sweep controller and its helpers.
package sweep_pkg;

  typedef enum logic [2:0] {
    IDLE,
    APPLY,
    SAMPLE,
    EMIT,
    DONE
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r = r + 1;
    return r;
  endfunction

  localparam int DEF_NUM_IN  = 7;
  localparam int DEF_NUM_OUT = 4;
  localparam int W_HD  = clog2(DEF_NUM_OUT + 1);
  localparam int W_SUM = DEF_NUM_IN + W_HD;

endpackage

// File: rtl/partition_sweep_ctrl_hamming.sv
// Hamming distance between two equal-width
// words: popcount(a ^ b).
module hamming_popcount
  import sweep_pkg::*;
#(
  parameter int WIDTH = 4,
  localparam int W_CNT = clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [W_CNT-1:0] count
);

  // Count differing bit positions.
  always_comb begin
    count = '0;
    for (int i = 0; i < WIDTH; i++) begin
      count = count + W_CNT'(a[i] ^ b[i]);
    end
  end

endmodule

// File: rtl/partition_sweep_ctrl.sv
// Exhaustive truth-table sweep of one partition
// with streamed records and error metrics.
module partition_sweep_ctrl
  import sweep_pkg::*;
#(
  parameter int NUM_IN  = 7,
  parameter int NUM_OUT = 4,
  parameter int SETTLE  = 1,
  localparam int HD_W  = clog2(NUM_OUT + 1),
  localparam int SUM_W = NUM_IN + HD_W
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               abort,
  output logic [NUM_IN-1:0]  pi,
  input  logic [NUM_OUT-1:0] po_approx,
  input  logic [NUM_OUT-1:0] po_exact,
  output logic               rec_valid,
  input  logic               rec_ready,
  output logic [NUM_IN-1:0]  rec_idx,
  output logic [NUM_OUT-1:0] rec_po,
  output logic [HD_W-1:0]    rec_hd,
  output logic               busy,
  output logic               done,
  output logic [NUM_IN:0]    err_count,
  output logic [SUM_W-1:0]   hd_sum,
  output logic [HD_W-1:0]    hd_max
);

  state_t state;
  state_t nxt;

  logic [3:0]        cnt;
  logic [NUM_IN-1:0] idx;
  logic [HD_W-1:0]   hd;
  logic              xfer;
  logic              last;
  logic              settle_end;
  logic              go;

  hamming_popcount #(
    .WIDTH(NUM_OUT)
  ) u_hd (
    .a    (po_approx),
    .b    (po_exact),
    .count(hd)
  );

  assign xfer       = rec_valid && rec_ready;
  assign last       = (idx == {NUM_IN{1'b1}});
  assign settle_end = (cnt == 4'(SETTLE - 1));
  assign go         = start && !abort;
  assign pi         = idx;
  assign rec_idx    = idx;

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= nxt;
  end

  // Next-state decode; abort wins over everything.
  always_comb begin
    nxt = state;
    unique case (state)
      IDLE:   if (go) nxt = APPLY;
      APPLY:  begin
        if (abort)           nxt = IDLE;
        else if (settle_end) nxt = SAMPLE;
      end
      SAMPLE: nxt = abort ? IDLE : EMIT;
      EMIT:   begin
        if (abort)     nxt = IDLE;
        else if (xfer) nxt = last ? DONE : APPLY;
      end
      DONE:   nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Status outputs are pure state decodes.
  always_comb begin
    busy      = 1'b0;
    rec_valid = 1'b0;
    done      = 1'b0;
    unique case (1'b1)
      (state == APPLY):  busy = 1'b1;
      (state == SAMPLE): busy = 1'b1;
      (state == EMIT): begin
        busy      = 1'b1;
        rec_valid = 1'b1;
      end
      (state == DONE):   done = 1'b1;
      default: ;
    endcase
  end

  // Settle counter, pattern index, record and metrics.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt       <= '0;
      idx       <= '0;
      rec_po    <= '0;
      rec_hd    <= '0;
      err_count <= '0;
      hd_sum    <= '0;
      hd_max    <= '0;
    end else begin
      if (state == APPLY && !abort && !settle_end)
        cnt <= cnt + 4'd1;
      else
        cnt <= '0;

      if (state == IDLE && go) begin
        idx       <= '0;
        err_count <= '0;
        hd_sum    <= '0;
        hd_max    <= '0;
      end

      if (state == SAMPLE && !abort) begin
        rec_po    <= po_approx;
        rec_hd    <= hd;
        err_count <= err_count + (NUM_IN + 1)'(hd != '0);
        hd_sum    <= hd_sum + SUM_W'(hd);
        if (hd > hd_max) hd_max <= hd;
      end

      if (state == EMIT && !abort && xfer && !last)
        idx <= idx + 1'b1;
    end
  end

endmodule

// File: tb/tb_partition_sweep_ctrl.sv
// Directed bench for partition_sweep_ctrl with
// default parameters (7 in, 4 out, settle 1).
module tb_partition_sweep_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [6:0] pi;
  logic [3:0] po_approx;
  logic [3:0] po_exact;
  logic       rec_valid;
  logic       rec_ready;
  logic [6:0] rec_idx;
  logic [3:0] rec_po;
  logic [2:0] rec_hd;
  logic       busy;
  logic       done;
  logic [7:0] err_count;
  logic [9:0] hd_sum;
  logic [2:0] hd_max;

  int mode = 0;
  int vectors = 0;
  int miscompares = 0;
  int ncyc;
  int nrec;

  partition_sweep_ctrl dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start),
    .abort    (abort),
    .pi       (pi),
    .po_approx(po_approx),
    .po_exact (po_exact),
    .rec_valid(rec_valid),
    .rec_ready(rec_ready),
    .rec_idx  (rec_idx),
    .rec_po   (rec_po),
    .rec_hd   (rec_hd),
    .busy     (busy),
    .done     (done),
    .err_count(err_count),
    .hd_sum   (hd_sum),
    .hd_max   (hd_max)
  );

  always #5 clk = ~clk;

  always_comb begin
    po_exact  = pi[3:0];
    po_approx = pi[3:0];
    if (mode == 1 && pi[0])
      po_approx = pi[3:0] ^ 4'b0001;
    else if (mode == 2 && pi == 7'd127)
      po_approx = ~pi[3:0];
  end

  function automatic logic [3:0] mpo(int m, int i);
    logic [6:0] ii;
    logic [3:0] e;
    ii = 7'(i);
    e  = ii[3:0];
    if (m == 1 && ii[0]) e = e ^ 4'b0001;
    if (m == 2 && i == 127) e = ~e;
    return e;
  endfunction

  function automatic int mhd(int m, int i);
    if (m == 1) return i % 2;
    if (m == 2) return (i == 127) ? 4 : 0;
    return 0;
  endfunction

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  task automatic chk_zero(input string tag);
    check({tag, "_pi"},   32'(pi),        0);
    check({tag, "_val"},  32'(rec_valid), 0);
    check({tag, "_idx"},  32'(rec_idx),   0);
    check({tag, "_po"},   32'(rec_po),    0);
    check({tag, "_hd"},   32'(rec_hd),    0);
    check({tag, "_busy"}, 32'(busy),      0);
    check({tag, "_done"}, 32'(done),      0);
    check({tag, "_err"},  32'(err_count), 0);
    check({tag, "_sum"},  32'(hd_sum),    0);
    check({tag, "_max"},  32'(hd_max),    0);
  endtask

  task automatic metrics(input string tag, input int e,
                         input int s, input int m);
    check({tag, "_err"}, 32'(err_count), 32'(e));
    check({tag, "_sum"}, 32'(hd_sum),    32'(s));
    check({tag, "_max"}, 32'(hd_max),    32'(m));
  endtask

  task automatic run(input int m, input int rm,
                     input int abort_at, input int rst_at,
                     output int cyc, output int recs);
    int n;
    int ei;
    int stall;
    bit fin;
    mode = m;
    cyc  = -1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    check("start_busy", 32'(busy),      1);
    check("start_pi",   32'(pi),        0);
    check("start_err",  32'(err_count), 0);
    check("start_sum",  32'(hd_sum),    0);
    check("start_max",  32'(hd_max),    0);
    n = 0; ei = 0; stall = 0; fin = 1'b0;
    while (!fin && n < 4000) begin
      if (rm == 0) begin
        rec_ready = 1'b1;
      end else if (rec_valid && int'(rec_idx) == 5
                   && stall < 10) begin
        rec_ready = 1'b0;
        stall++;
        check("stall_idx", 32'(rec_idx), 5);
        check("stall_pi",  32'(pi),      5);
        check("stall_po",  32'(rec_po),  32'(mpo(m, 5)));
      end else begin
        rec_ready = ($urandom % 4) != 0;
      end
      start = (rm == 1 && ei == 10) ? 1'b1 : 1'b0;
      if (done) begin
        cyc = n;
        fin = 1'b1;
      end else if (rst_at >= 0 && busy && !rec_valid
                   && int'(pi) == rst_at) begin
        fin = 1'b1;
        #2 rst_n = 1'b0;
        #1 chk_zero("async_rst");
      end else if (abort_at >= 0 && rec_valid
                   && int'(rec_idx) == abort_at) begin
        abort     = 1'b1;
        rec_ready = 1'b1;
        fin       = 1'b1;
      end else if (rec_valid && rec_ready) begin
        check("rec_idx", 32'(rec_idx), 32'(ei));
        check("rec_pi",  32'(pi),      32'(ei));
        check("rec_po",  32'(rec_po),  32'(mpo(m, ei)));
        check("rec_hd",  32'(rec_hd),  32'(mhd(m, ei)));
        ei++;
      end
      @(negedge clk);
      n++;
    end
    abort = 1'b0;
    start = 1'b0;
    rst_n = 1'b1;
    if (!fin) check("timeout", 0, 1);
    recs = ei;
  endtask

  task automatic after_done(input string tag);
    check({tag, "_done1"}, 32'(done), 0);
    check({tag, "_busy"},  32'(busy), 0);
    check({tag, "_pi"},    32'(pi),   127);
  endtask

  initial begin
    rst_n     = 1'b0;
    start     = 1'b0;
    abort     = 1'b0;
    rec_ready = 1'b0;
    @(negedge clk);
    chk_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk_zero("idle");

    run(0, 0, -1, -1, ncyc, nrec);
    check("m0_cycles", 32'(ncyc), 384);
    check("m0_recs",   32'(nrec), 128);
    after_done("m0");
    metrics("m0", 0, 0, 0);

    run(1, 0, -1, -1, ncyc, nrec);
    check("m1_cycles", 32'(ncyc), 384);
    check("m1_recs",   32'(nrec), 128);
    after_done("m1");
    metrics("m1", 64, 64, 1);

    run(2, 0, -1, -1, ncyc, nrec);
    check("m2_recs", 32'(nrec), 128);
    after_done("m2");
    metrics("m2", 1, 4, 4);

    run(1, 1, -1, -1, ncyc, nrec);
    check("rnd_recs", 32'(nrec), 128);
    after_done("rnd");
    metrics("rnd", 64, 64, 1);

    run(1, 0, 40, -1, ncyc, nrec);
    check("ab_recs",  32'(nrec),      40);
    check("ab_busy",  32'(busy),      0);
    check("ab_valid", 32'(rec_valid), 0);
    check("ab_done",  32'(done),      0);
    metrics("ab", 20, 20, 1);
    repeat (3) begin
      @(negedge clk);
      check("ab_nodone", 32'(done), 0);
    end
    metrics("ab_hold", 20, 20, 1);

    run(2, 0, -1, -1, ncyc, nrec);
    check("re_recs", 32'(nrec), 128);
    after_done("re");
    metrics("re", 1, 4, 4);

    run(1, 0, -1, 17, ncyc, nrec);
    check("rst_recs", 32'(nrec), 17);
    @(negedge clk);
    chk_zero("post_rst");

    start = 1'b1;
    abort = 1'b1;
    @(negedge clk);
    start = 1'b0;
    abort = 1'b0;
    check("st_ab_busy", 32'(busy), 0);
    @(negedge clk);
    check("st_ab_busy2", 32'(busy), 0);

    run(0, 0, -1, -1, ncyc, nrec);
    check("fin_cycles", 32'(ncyc), 384);
    check("fin_recs",   32'(nrec), 128);
    after_done("fin");
    metrics("fin", 0, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/partition_sweep_ctrl.md
Name: partition_sweep_ctrl

Overview:
- Hardware sequencer for exhaustive truth-table evaluation of one combinational partition.
- Drives every input pattern 0 .. 2^NUM_IN-1 onto the partition inputs. Samples the approximate partition outputs alongside the exact (golden) partition outputs.
- Streams per-pattern records out through a valid/ready port.
- Accumulates error metrics: mismatching patterns, total Hamming distance, maximum Hamming distance. These feed the approximation-quality loop.

Parameters:
- NUM_IN, 7, partition input width; legal range 1..16.
- NUM_OUT, 4, partition output width; legal range 1..32.
- SETTLE, 1, cycles each pattern is held before sampling; legal range 1..15.

Ports:
- clk  input  1  clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  begin a sweep; honoured only in IDLE
- abort  input  1  cancel the sweep in progress
- pi  output  NUM_IN  pattern driven to both partitions
- po_approx  input  NUM_OUT  approximate partition output
- po_exact  input  NUM_OUT  exact partition output
- rec_valid  output  1  record available
- rec_ready  input  1  consumer accepts record
- rec_idx  output  NUM_IN  pattern index of record
- rec_po  output  NUM_OUT  captured po_approx
- rec_hd  output  W_HD  Hamming distance of record; W_HD = clog2(NUM_OUT+1)
- busy  output  1  sweep in progress
- done  output  1  one-cycle pulse on sweep completion
- err_count  output  NUM_IN+1  number of patterns with po_approx != po_exact
- hd_sum  output  NUM_IN+W_HD  sum of Hamming distances
- hd_max  output  W_HD  largest Hamming distance seen

Behaviour:
- Reset (async, rst_n low): all outputs 0, state IDLE, index 0, settle counter 0.
- States and transitions:
  - IDLE: start=1 → clear err_count, hd_sum, hd_max and index; next state APPLY. start is ignored in all other states.
  - APPLY: pi = index. Settle counter runs 0..SETTLE-1, then SAMPLE.
  - SAMPLE: register po_approx and hd = popcount(po_approx ^ po_exact).
    - If hd != 0, err_count += 1.
    - hd_sum += hd.
    - hd_max = max(hd_max, hd).
    - Next state EMIT.
  - EMIT: rec_valid=1, with rec_idx/rec_po/rec_hd stable from the SAMPLE capture.
    - Transfer occurs on rec_valid && rec_ready.
    - On transfer with index == 2^NUM_IN-1 → DONE.
    - On transfer otherwise → index+1, APPLY.
    - No transfer → hold; record fields and pi must not change.
  - DONE: done=1 for exactly one cycle → IDLE.
- pi holds its last value in SAMPLE, EMIT, DONE and IDLE. It is not reset by a sweep completing; only rst_n or the next start clears it.
- busy=1 in APPLY, SAMPLE and EMIT; 0 in IDLE and DONE.
- Throughput with rec_ready held high: SETTLE+2 cycles per pattern. Total = 2^NUM_IN*(SETTLE+2) cycles from the first APPLY to DONE.
- Index wrap: the index is never incremented past 2^NUM_IN-1. No modular wrap occurs.
- Counters are sized so they cannot overflow: err_count max 2^NUM_IN, hd_sum max 2^NUM_IN*NUM_OUT.
- abort=1 in any non-IDLE state → IDLE on the next edge.
  - rec_valid drops and done is not pulsed.
  - Metrics hold their partial values.
  - abort has priority over a simultaneous transfer.
- abort together with start in IDLE → remain IDLE.
- rec_valid never depends combinationally on rec_ready.
- Metric outputs are stable whenever busy=0.

Decomposition:
- Shared package sweep_pkg holds:
  - state enum {IDLE, APPLY, SAMPLE, EMIT, DONE};
  - constant function clog2;
  - width-derivation localparams W_HD and W_SUM.
- One combinational sub-module, hamming_popcount: parameter WIDTH, inputs a and b, output count = popcount(a^b). It is reused by the offline error-metric blocks.

Test Plan:
- Identical partitions (po_approx = po_exact = pi[3:0]), NUM_IN=7, NUM_OUT=4, SETTLE=1, rec_ready=1, pulse start → 128 records with rec_idx 0..127 in order; done pulses at cycle 384 after the first APPLY; err_count=0, hd_sum=0, hd_max=0.
- po_approx = po_exact ^ 4'b0001 only when pi[0]=1 → err_count=64, hd_sum=64, hd_max=1; rec_hd alternates 0,1.
- po_approx = ~po_exact for pi=127 only → err_count=1, hd_sum=4, hd_max=4; the record for idx 127 carries rec_hd=4.
- rec_ready toggled randomly, with a stall of 10 cycles at idx 5 → rec_idx/rec_po/pi constant during the stall; no record is dropped or duplicated; the final metrics match the rec_ready=1 run.
- abort asserted in EMIT at idx 40 → IDLE next cycle, busy=0, no done pulse, err_count reflects idx 0..40. A subsequent start clears the metrics and restarts from idx 0.
- rst_n pulled low mid-APPLY at idx 17 → all outputs 0 immediately (asynchronous). After release, start while busy is not required; a second start raised during a sweep is ignored.
